// File: rtl/seq_operand_stack.sv
// Operand stack sequencer: decodes stack instructions, issues operands to an
// external ALU and writes the returned result back onto the stack.
module seq_operand_stack #(
  parameter int alu_width    = 16,
  parameter int seq_op_width = 3,
  parameter int seq_im_width = 8,
  parameter int stack_depth  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [seq_op_width-1:0]           i_op,
  input  logic [seq_im_width-1:0]           i_const,
  input  logic                              i_valid,
  output logic                              o_ready,
  output logic [alu_width-1:0]              o_alu_a,
  output logic [alu_width-1:0]              o_alu_b,
  output logic [seq_op_width-1:0]           o_alu_op,
  output logic [seq_im_width-1:0]           o_alu_const,
  output logic                              o_alu_valid,
  input  logic [alu_width-1:0]              i_alu_data,
  input  logic                              i_alu_valid,
  output logic [alu_width-1:0]              o_tos,
  output logic [$clog2(stack_depth):0]      o_depth,
  output logic                              o_error
);
  localparam int PW = $clog2(stack_depth);
  localparam int DW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [seq_op_width-1:0] OP_PUSH = seq_op_width'(1);
  localparam logic [seq_op_width-1:0] OP_ADD  = seq_op_width'(2);
  localparam logic [seq_op_width-1:0] OP_MULT = seq_op_width'(3);
  localparam logic [seq_op_width-1:0] OP_POP  = seq_op_width'(4);

  logic [1:0]              state_q, state_d;
  logic [DW-1:0]           depth_q, depth_d;
  logic                    error_q, error_d;
  logic [alu_width-1:0]    alu_a_q, alu_a_d;
  logic [alu_width-1:0]    alu_b_q, alu_b_d;
  logic [seq_op_width-1:0] alu_op_q, alu_op_d;
  logic [seq_im_width-1:0] alu_const_q, alu_const_d;
  logic [alu_width-1:0]    entries_q [stack_depth];
  logic [alu_width-1:0]    entries_d [stack_depth];

  logic [PW-1:0] tos_idx, nos_idx, push_idx;
  assign tos_idx  = PW'(depth_q - DW'(1));
  assign nos_idx  = PW'(depth_q - DW'(2));
  assign push_idx = depth_q[PW-1:0];

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    error_d     = error_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_const_d = alu_const_q;
    entries_d   = entries_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          case (i_op)
            OP_PUSH: begin
              if (depth_q == DW'(stack_depth)) begin
                error_d = 1'b1;
              end else begin
                alu_a_d     = '0;
                alu_b_d     = '0;
                alu_op_d    = OP_PUSH;
                alu_const_d = i_const;
                state_d     = S_EXEC;
              end
            end
            OP_ADD, OP_MULT: begin
              if (depth_q < DW'(2)) begin
                error_d = 1'b1;
              end else begin
                alu_a_d     = entries_q[tos_idx];
                alu_b_d     = entries_q[nos_idx];
                alu_op_d    = i_op;
                alu_const_d = i_const;
                state_d     = S_EXEC;
              end
            end
            OP_POP: begin
              if (depth_q == '0) error_d = 1'b1;
              else               depth_d = depth_q - DW'(1);
            end
            default: ;
          endcase
        end
      end
      S_EXEC, S_WAIT: begin
        // Binary ops collapse TOS/NOS into a single entry at the NOS slot.
        if (i_alu_valid) begin
          if (alu_op_q == OP_PUSH) begin
            entries_d[push_idx] = i_alu_data;
            depth_d             = depth_q + DW'(1);
          end else begin
            entries_d[nos_idx] = i_alu_data;
            depth_d            = depth_q - DW'(1);
          end
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      error_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_const_q <= '0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      error_q     <= error_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_const_q <= alu_const_d;
    end
  end

  // Entry contents are never reset; depth gates their visibility.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_alu_valid = (state_q == S_EXEC);
  assign o_alu_a     = alu_a_q;
  assign o_alu_b     = alu_b_q;
  assign o_alu_op    = alu_op_q;
  assign o_alu_const = alu_const_q;
  assign o_tos       = (depth_q == '0) ? '0 : entries_q[tos_idx];
  assign o_depth     = depth_q;
  assign o_error     = error_q;
endmodule

// File: tb/tb_seq_operand_stack.sv
// Bench for seq_operand_stack: queue-based stack model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seq_operand_stack;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  i_op;
  logic [7:0]  i_const;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_alu_a, o_alu_b;
  logic [2:0]  o_alu_op;
  logic [7:0]  o_alu_const;
  logic        o_alu_valid;
  logic [15:0] i_alu_data;
  logic        i_alu_valid;
  logic [15:0] o_tos;
  logic [3:0]  o_depth;
  logic        o_error;

  seq_operand_stack dut (
    .clk(clk), .rst(rst), .i_op(i_op), .i_const(i_const), .i_valid(i_valid),
    .o_ready(o_ready), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .o_alu_const(o_alu_const), .o_alu_valid(o_alu_valid), .i_alu_data(i_alu_data),
    .i_alu_valid(i_alu_valid), .o_tos(o_tos), .o_depth(o_depth), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: stack as a queue, a busy flag while an ALU result is outstanding.
  logic [15:0] m_stk[$];
  bit          m_err, m_busy, m_issue, chk_en;
  logic [15:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [7:0]  m_const;

  logic [15:0] iss_a, iss_b;
  logic        iss_v;
  int          low;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_stk.delete();
      m_err = 0; m_busy = 0; m_issue = 0;
    end else begin
      m_issue = 0;
      if (m_busy) begin
        if (i_alu_valid) begin
          if (m_op == 3'd1) m_stk.push_back(i_alu_data);
          else begin
            void'(m_stk.pop_back());
            void'(m_stk.pop_back());
            m_stk.push_back(i_alu_data);
          end
          m_busy = 0;
        end
      end else if (i_valid) begin
        case (i_op)
          3'd1: if (m_stk.size() == 8) m_err = 1;
                else begin
                  m_busy = 1; m_issue = 1; m_a = 0; m_b = 0; m_op = 1; m_const = i_const;
                end
          3'd2, 3'd3: if (m_stk.size() < 2) m_err = 1;
                else begin
                  m_busy = 1; m_issue = 1; m_op = i_op; m_const = i_const;
                  m_a = m_stk[m_stk.size()-1];
                  m_b = m_stk[m_stk.size()-2];
                end
          3'd4: if (m_stk.size() == 0) m_err = 1;
                else void'(m_stk.pop_back());
          default: ;
        endcase
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("depth", o_depth, m_stk.size());
      chk("tos", o_tos, (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1]);
      chk("error", o_error, m_err);
      chk("ready", o_ready, !m_busy);
      chk("alu_valid", o_alu_valid, m_issue);
      if (m_busy) begin
        chk("alu_a", o_alu_a, m_a);
        chk("alu_b", o_alu_b, m_b);
        chk("alu_op", o_alu_op, m_op);
        chk("alu_const", o_alu_const, m_const);
      end
    end
  end

  task automatic reset_dut();
    rst = 1; tick(); rst = 0;
  endtask

  // Issue one instruction; if accepted, play the ALU returning after lat cycles.
  task automatic run_op(input logic [2:0] op, input logic [7:0] c, input int lat);
    logic [15:0] data;
    i_valid = 1; i_op = op; i_const = c;
    tick();
    i_valid = 0; i_op = 0; i_const = 0;
    low = 0;
    if (m_busy) begin
      case (m_op)
        3'd1:    data = {8'd0, m_const};
        3'd2:    data = m_a + m_b;
        default: data = 16'(m_a * m_b);
      endcase
      i_alu_data = data;
      for (int k = 0; k <= lat; k++) begin
        i_alu_valid = (k == lat);
        @(negedge clk);
        if (k == 0) begin iss_a = o_alu_a; iss_b = o_alu_b; iss_v = o_alu_valid; end
        if (!o_ready) low++;
        tick();
      end
      i_alu_valid = 0;
    end else begin
      @(negedge clk);
      iss_v = o_alu_valid;
      if (!o_ready) low++;
    end
  endtask

  initial begin
    rst = 1; i_op = 0; i_const = 0; i_valid = 0; i_alu_data = 0; i_alu_valid = 0;
    chk_en = 0;
    tick(); tick();
    chk_en = 1;
    @(negedge clk);
    chk("rst_depth", o_depth, 0);
    chk("rst_tos", o_tos, 0);
    chk("rst_error", o_error, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_aluv", o_alu_valid, 0);
    chk("rst_alu_a", o_alu_a, 0);
    chk("rst_alu_op", o_alu_op, 0);
    chk("rst_alu_const", o_alu_const, 0);
    rst = 0;

    // push 5, push 7, add with same-cycle ALU result
    run_op(1, 5, 0); run_op(1, 7, 0); run_op(2, 0, 0);
    chk("add_a", iss_a, 7); chk("add_b", iss_b, 5); chk("add_v", iss_v, 1);
    chk("add_ready_low", low, 1);
    @(negedge clk);
    chk("add_tos", o_tos, 12); chk("add_depth", o_depth, 1); chk("add_err", o_error, 0);

    // mult with slow ALU
    reset_dut();
    run_op(1, 3, 0); run_op(1, 4, 0); run_op(3, 0, 3);
    chk("mult_ready_low", low, 4);
    chk("mult_a", iss_a, 4); chk("mult_b", iss_b, 3);
    @(negedge clk);
    chk("mult_tos", o_tos, 12); chk("mult_depth", o_depth, 1);

    // add with a single entry underflows
    reset_dut();
    run_op(1, 9, 0); run_op(2, 0, 0);
    chk("uf_aluv", iss_v, 0);
    chk("uf_err", o_error, 1); chk("uf_depth", o_depth, 1); chk("uf_tos", o_tos, 9);

    // normal pop
    reset_dut();
    run_op(1, 1, 1); run_op(1, 2, 2); run_op(4, 0, 0);
    chk("pop_tos", o_tos, 1); chk("pop_depth", o_depth, 1); chk("pop_err", o_error, 0);

    // results wrap at the data width
    reset_dut();
    run_op(1, 255, 0); run_op(1, 255, 0); run_op(3, 0, 1);
    chk("m255_tos", o_tos, 16'hFE01);
    run_op(1, 255, 0); run_op(2, 0, 2);
    chk("a255_tos", o_tos, 16'hFF00);
    run_op(1, 255, 0); run_op(3, 0, 0);
    chk("trunc_tos", o_tos, 16'h0100);

    // overflow after 8 pushes
    reset_dut();
    for (int n = 1; n <= 8; n++) run_op(1, 8'(n), 0);
    chk("full_err", o_error, 0);
    run_op(1, 9, 0);
    chk("of_depth", o_depth, 8); chk("of_tos", o_tos, 8); chk("of_err", o_error, 1);

    // reset while waiting on ALU, late result ignored
    reset_dut();
    i_valid = 1; i_op = 1; i_const = 8'd42; tick();
    i_valid = 0; i_op = 0; i_const = 0;
    tick();
    rst = 1; tick(); rst = 0;
    i_alu_data = 16'd42; i_alu_valid = 1; tick(); i_alu_valid = 0;
    @(negedge clk);
    chk("rw_depth", o_depth, 0); chk("rw_ready", o_ready, 1);
    chk("rw_tos", o_tos, 0); chk("rw_err", o_error, 0);

    // pop on empty, then nop and reserved opcode
    reset_dut();
    run_op(4, 0, 0); chk("pe_ready", low, 0);
    run_op(0, 0, 0); chk("nop_ready", low, 0);
    run_op(6, 0, 0); chk("op6_ready", low, 0);
    chk("pe_err", o_error, 1); chk("pe_depth", o_depth, 0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_operand_stack.md
SEQ_OPERAND_STACK -- requirements
Module: seq_operand_stack

Interface
REQ-001 Parameter alu_width, default 16, SHALL set the data path and stack entry width.
REQ-002 Parameter seq_op_width, default 3, SHALL set the opcode width.
REQ-003 Parameter seq_im_width, default 8, SHALL set the immediate width.
REQ-004 Parameter stack_depth, default 8, SHALL set the number of stack entries; legal values are powers of two, 2 or more.
REQ-005 Opcodes SHALL be: nop=0, push=1, add=2, mult=3, pop=4; codes 5-7 SHALL behave as nop.
REQ-006 Ports SHALL be:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_op  in  seq_op_width  instruction opcode.
- i_const  in  seq_im_width  instruction immediate.
- i_valid  in  1  instruction present.
- o_ready  out  1  instruction accepted when i_valid and o_ready are both high.
- o_alu_a  out  alu_width  ALU operand A.
- o_alu_b  out  alu_width  ALU operand B.
- o_alu_op  out  seq_op_width  ALU opcode.
- o_alu_const  out  seq_im_width  ALU immediate.
- o_alu_valid  out  1  ALU issue strobe.
- i_alu_data  in  alu_width  ALU result.
- i_alu_valid  in  1  ALU result valid.
- o_tos  out  alu_width  top of stack; 0 when empty.
- o_depth  out  log2(stack_depth)+1  current entry count.
- o_error  out  1  sticky underflow/overflow flag.

Function
REQ-007 The FSM SHALL have three states: IDLE, EXEC and WAIT; o_ready SHALL be high only in IDLE.
REQ-008 On accept of a nop, the block SHALL stay in IDLE with no state change.
REQ-009 On accept of a pop:
- depth>0: depth SHALL decrement.
- depth==0: o_error SHALL be set and depth SHALL be unchanged.
- In both cases the block SHALL stay in IDLE.
REQ-010 On accept of a push:
- depth==stack_depth: o_error SHALL be set, the instruction SHALL be dropped, and the block SHALL stay in IDLE.
- Otherwise: o_alu_a=0, o_alu_b=0, o_alu_const=i_const, o_alu_op=push SHALL be registered, and the block SHALL go to EXEC.
REQ-011 On accept of add or mult:
- depth<2: o_error SHALL be set, the stack SHALL be unchanged, and the block SHALL stay in IDLE.
- Otherwise: o_alu_a=entry[depth-1] (TOS), o_alu_b=entry[depth-2] (NOS), o_alu_const=i_const, o_alu_op=i_op SHALL be registered, and the block SHALL go to EXEC.
REQ-012 o_alu_valid SHALL be high for exactly the one cycle spent in EXEC, and low in all other states.
REQ-013 o_alu_a, o_alu_b, o_alu_op and o_alu_const SHALL hold stable from entry to EXEC until the result is captured.
REQ-014 Result capture, in EXEC or WAIT, whenever i_alu_valid is high:
- push: entry[depth]=i_alu_data and depth+1.
- add/mult: entry[depth-2]=i_alu_data and depth-1.
- The block SHALL then return to IDLE.
REQ-015 In EXEC with i_alu_valid low, the block SHALL go to WAIT and remain there until i_alu_valid is high; there is no timeout.
REQ-016 i_alu_valid in IDLE SHALL be ignored.
REQ-017 Single-cycle ALU path: an add issued in EXEC with i_alu_valid high the same cycle SHALL complete in that cycle, giving accept-to-ready latency of 2 cycles.
REQ-018 Results SHALL be stored as delivered, with no width extension or saturation.
REQ-019 o_tos and o_depth SHALL be combinational functions of registered state only.
REQ-020 o_error SHALL remain high once set, until reset.

Reset
REQ-021 While rst is high at a rising edge, the block SHALL:
- set state=IDLE, depth=0, o_error=0, o_alu_valid=0;
- set o_alu_a=0, o_alu_b=0, o_alu_op=0, o_alu_const=0;
- leave stack entry contents undefined and unobservable (o_tos=0).
REQ-022 Reset during EXEC or WAIT SHALL discard the pending operation; a late i_alu_valid SHALL be ignored.

Verification
REQ-023 push 5, push 7, add with combinational ALU -> o_alu_a=7, o_alu_b=5 in EXEC; afterwards o_tos=12, o_depth=1, o_error=0.
REQ-024 push 3, push 4, mult with i_alu_valid 3 cycles after EXEC -> o_ready low for 4 cycles, operands stable throughout; afterwards o_tos=12, o_depth=1.
REQ-025 push 9, add -> o_error=1, o_depth=1, o_tos=9, no o_alu_valid pulse for the add.
REQ-026 9 pushes of 1..9 with stack_depth=8 -> o_depth=8, o_tos=8, o_error=1 after the 9th.
REQ-027 push issued, rst asserted in WAIT, i_alu_valid a cycle later -> o_depth=0, o_ready=1, o_tos=0, o_error=0.
REQ-028 pop on empty, then nop and op code 6 -> o_error=1, o_depth=0, o_ready high every cycle.
